sys_commit: RTL and testbench
=============================

Name: sys_commit

Overview:
Commit-stage consumer of the system-op checker. Takes a validated SYS instruction plus the checker's bad-CSR/trap flags and performs the architectural side effects: CSR read-modify-write, trap entry (ECALL/EBREAK/illegal CSR), and MRET. Owns the RV32 machine-mode trap CSRs and the 64-bit cycle/instret counters. Drives a PC redirect to fetch and the updated program state back to the pipeline.

Parameters:
HART_ID, 0, value returned by mhartid (0xf14)
RESET_MTVEC, 32'h0000_0000, mtvec reset value

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_e  in  1  valid SYS op at commit; sampled only when o_ready=1
i_op  in  decode_sys_op_t  op class
i_csr  in  12  CSR number
i_wdata  in  32  rs1 value or zero-extended zimm
i_rs1_is_zero  in  1  rs1/zimm field is zero
i_bad_csr  in  1  illegal-CSR flag from checker
i_trap  in  1  trap/return-op flag from checker
i_pc  in  32  PC of the op
i_instr  in  32  raw encoding, used for mtval
i_retire  in  1  one instruction retired this cycle (instret tick)
o_ready  out  1  block is IDLE and accepts i_e
o_done  out  1  one-cycle pulse: op finished
o_rd_data  out  32  old CSR value, valid with o_done
o_redirect  out  1  one-cycle pulse with o_done on trap/MRET
o_redirect_pc  out  32  target PC, valid with o_redirect
o_ps  out  program_state_t  current program state (priv)

Behaviour:
- Reset: state IDLE; o_ready=1; o_done=o_redirect=0; o_rd_data=o_redirect_pc=0; priv=M; mstatus.MIE=0, MPIE=0, MPP=U; mtvec=RESET_MTVEC; mepc=mcause=mtval=mscratch=0; counters=0. Reset mid-op discards the op; no CSR is written.
- FSM: IDLE, CSR_RMW, TRAP_SAVE, TRAP_JUMP, RET. o_ready=1 only in IDLE. i_e while not IDLE is ignored; upstream holds.
- IDLE on i_e, priority: i_bad_csr -> TRAP_SAVE (cause 2, tval=i_instr); ECALL -> TRAP_SAVE (cause 8/9/11 for priv U/S/M, tval=0); EBREAK -> TRAP_SAVE (cause 3, tval=i_pc); MRET with priv=M -> RET, otherwise illegal (cause 2); SRET/URET -> illegal (cause 2); CSR op -> CSR_RMW. All inputs are latched on accept.
- CSR_RMW (1 cycle): read old value, then write SWAP=wdata, SET=old|wdata, CLEAR=old&~wdata. Skip the write when SET/CLEAR has rs1 zero. Pulse o_done with o_rd_data=old. Go to IDLE. Total latency is 2 cycles from accept.
- Writable: mstatus (only MIE bit3, MPIE bit7, MPP bits12:11; MPP writes of 2'b10 are ignored), mtvec (bits1:0 forced 0, direct mode only), mepc (bits1:0 forced 0), mcause, mtval, mscratch, mcycle(0xb00)/minstret(0xb02) low word.
- Read-only but readable: cycle/time/instret and their h variants. time aliases cycle. mhartid=HART_ID. misa=32'h4000_1101 (RV32IMA). Every other number the checker passes reads 0 and ignores writes.
- TRAP_SAVE: mepc<=pc, mcause<=cause, mtval<=tval, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M. Then TRAP_JUMP.
- TRAP_JUMP: o_done=1, o_redirect=1, o_redirect_pc=mtvec, o_rd_data=0. Then IDLE. Total latency is 3 cycles.
- RET (1 cycle): priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=U. Pulse o_done and o_redirect with o_redirect_pc=mepc. Then IDLE.
- Counters: mcycle increments every cycle and wraps at 2^64. minstret increments when i_retire=1. A CSR write to a counter in the same cycle overrides the increment for that half. The upper half is unchanged by a low-word write.

Decomposition:
- Shared package: cause codes (EXC_ILLEGAL=2, EXC_BREAKPOINT=3, EXC_ECALL_U/S/M=8/9/11), CSR address constants, mstatus bit-position constants, sys_commit_state_t enum.
- Existing types reused: decode_sys_op_t, program_state_t, PRIV_MODE_*.
- One sub-module: sys_counters, holding 64-bit mcycle/minstret with increment, write-low port and read mux.

Test Plan:
- Reset, then CSRRW mscratch with wdata=32'hdead_beef, then CSRRS mscratch with rs1=0: first o_done gives rd=0; second gives rd=32'hdead_beef and mscratch is unchanged.
- In priv U, ECALL at pc=32'h100, mtvec=32'h8000_0000: o_redirect at cycle 3 to 32'h8000_0000; mcause=8, mepc=32'h100, priv=M, MPP=U, MIE=0.
- i_bad_csr=1, i_instr=32'hc0001073: mcause=2, mtval=32'hc0001073; redirect to mtvec.
- MRET with mepc=32'h2004, MPP=S, MPIE=1: redirect to 32'h2004 after 2 cycles; priv=S, MIE=1, MPIE=1, MPP=U.
- mcycle low word=32'hffff_ffff, then one tick: low word=0 and cycleh increments by 1. A CSRRW to mcycle with 5 in the same cycle leaves low word=5.
- Assert i_rst during TRAP_SAVE: no o_done or o_redirect; all CSRs return to reset values; o_ready=1 the cycle after deassert.

Source files
------------

// File: rtl/sys_commit_pkg.sv
// Shared types and constants for the SYS-op commit stage: op classes, privilege
// encodings, exception causes, CSR numbers, mstatus bit positions and FSM states.
package sys_commit_pkg;

  typedef enum logic [2:0] {
    SYS_OP_CSRRW,
    SYS_OP_CSRRS,
    SYS_OP_CSRRC,
    SYS_OP_ECALL,
    SYS_OP_EBREAK,
    SYS_OP_MRET,
    SYS_OP_SRET,
    SYS_OP_URET
  } decode_sys_op_t;

  localparam logic [1:0] PRIV_MODE_U = 2'b00;
  localparam logic [1:0] PRIV_MODE_S = 2'b01;
  localparam logic [1:0] PRIV_MODE_M = 2'b11;

  typedef struct packed {
    logic [1:0] priv;
  } program_state_t;

  localparam logic [31:0] EXC_ILLEGAL    = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT = 32'd3;
  localparam logic [31:0] EXC_ECALL_U    = 32'd8;
  localparam logic [31:0] EXC_ECALL_S    = 32'd9;
  localparam logic [31:0] EXC_ECALL_M    = 32'd11;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hb00;
  localparam logic [11:0] CSR_MINSTRET = 12'hb02;
  localparam logic [11:0] CSR_CYCLE    = 12'hc00;
  localparam logic [11:0] CSR_TIME     = 12'hc01;
  localparam logic [11:0] CSR_INSTRET  = 12'hc02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hc80;
  localparam logic [11:0] CSR_TIMEH    = 12'hc81;
  localparam logic [11:0] CSR_INSTRETH = 12'hc82;
  localparam logic [11:0] CSR_MHARTID  = 12'hf14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_1101;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSR_RMW,
    ST_TRAP_SAVE,
    ST_TRAP_JUMP,
    ST_RET
  } sys_commit_state_t;

  function automatic logic [31:0] ecall_cause(input logic [1:0] priv);
    case (priv)
      PRIV_MODE_U: ecall_cause = EXC_ECALL_U;
      PRIV_MODE_S: ecall_cause = EXC_ECALL_S;
      default:     ecall_cause = EXC_ECALL_M;
    endcase
  endfunction

endpackage

// File: rtl/sys_commit_counters.sv
// 64-bit mcycle/minstret counters with a low-word write port and the read mux
// for all counter CSR aliases (user-level views and machine low words).
module sys_counters
  import sys_commit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_retire,
  input  logic        i_wr_en,
  input  logic [11:0] i_wr_csr,
  input  logic [31:0] i_wr_data,
  input  logic [11:0] i_rd_csr,
  output logic [31:0] o_rd_data
);

  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wr_cycle;
  logic        wr_instret;

  assign wr_cycle   = i_wr_en && (i_wr_csr == CSR_MCYCLE);
  assign wr_instret = i_wr_en && (i_wr_csr == CSR_MINSTRET);

  // A low-word write replaces that cycle's increment, so no carry reaches the upper half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_cycle)
        mcycle[31:0] <= i_wr_data;
      else
        mcycle <= mcycle + 64'd1;

      if (wr_instret)
        minstret[31:0] <= i_wr_data;
      else if (i_retire)
        minstret <= minstret + 64'd1;
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_csr)
      CSR_MCYCLE, CSR_CYCLE, CSR_TIME: o_rd_data = mcycle[31:0];
      CSR_CYCLEH, CSR_TIMEH:           o_rd_data = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:       o_rd_data = minstret[31:0];
      CSR_INSTRETH:                    o_rd_data = minstret[63:32];
      default:                         o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/sys_commit.sv
// Commit-stage executor for SYS instructions: CSR read-modify-write, trap entry
// and MRET, owning the machine-mode trap CSRs and the current privilege level.
module sys_commit
  import sys_commit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_e,
  input  decode_sys_op_t i_op,
  input  logic [11:0]    i_csr,
  input  logic [31:0]    i_wdata,
  input  logic           i_rs1_is_zero,
  input  logic           i_bad_csr,
  input  logic           i_trap,
  input  logic [31:0]    i_pc,
  input  logic [31:0]    i_instr,
  input  logic           i_retire,
  output logic           o_ready,
  output logic           o_done,
  output logic [31:0]    o_rd_data,
  output logic           o_redirect,
  output logic [31:0]    o_redirect_pc,
  output program_state_t o_ps
);

  sys_commit_state_t state;

  decode_sys_op_t op_q;
  logic [11:0]    csr_q;
  logic [31:0]    wdata_q;
  logic           rs1_zero_q;
  logic [31:0]    pc_q;
  logic [31:0]    cause_q;
  logic [31:0]    tval_q;

  logic [1:0]  priv;
  logic        mie;
  logic        mpie;
  logic [1:0]  mpp;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [31:0] mscratch;

  sys_commit_state_t accept_state;
  logic [31:0]       accept_cause;
  logic [31:0]       accept_tval;
  logic [31:0]       mstatus_rd;
  logic [31:0]       cnt_rd_data;
  logic [31:0]       csr_old;
  logic [31:0]       csr_new;
  logic              csr_we;
  logic              unused_ok;

  // The checker's trap flag is implied by the op class; it is kept on the port for compatibility.
  assign unused_ok = ^{i_trap, pc_q[1:0]};

  assign o_ready = (state == ST_IDLE);
  assign o_ps    = program_state_t'{priv: priv};

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE_BIT]                = mie;
    mstatus_rd[MSTATUS_MPIE_BIT]               = mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = mpp;
  end

  always_comb begin
    accept_state = ST_TRAP_SAVE;
    accept_cause = EXC_ILLEGAL;
    accept_tval  = i_instr;
    if (!i_bad_csr) begin
      case (i_op)
        SYS_OP_ECALL: begin
          accept_cause = ecall_cause(priv);
          accept_tval  = '0;
        end
        SYS_OP_EBREAK: begin
          accept_cause = EXC_BREAKPOINT;
          accept_tval  = i_pc;
        end
        SYS_OP_MRET: begin
          if (priv == PRIV_MODE_M)
            accept_state = ST_RET;
        end
        SYS_OP_SRET, SYS_OP_URET: accept_state = ST_TRAP_SAVE;
        default: accept_state = ST_CSR_RMW;
      endcase
    end
  end

  sys_counters u_counters (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_retire  (i_retire),
    .i_wr_en   (csr_we),
    .i_wr_csr  (csr_q),
    .i_wr_data (csr_new),
    .i_rd_csr  (csr_q),
    .o_rd_data (cnt_rd_data)
  );

  always_comb begin
    csr_old = '0;
    case (csr_q)
      CSR_MSTATUS:  csr_old = mstatus_rd;
      CSR_MISA:     csr_old = MISA_VALUE;
      CSR_MTVEC:    csr_old = mtvec;
      CSR_MSCRATCH: csr_old = mscratch;
      CSR_MEPC:     csr_old = mepc;
      CSR_MCAUSE:   csr_old = mcause;
      CSR_MTVAL:    csr_old = mtval;
      CSR_MHARTID:  csr_old = HART_ID;
      default:      csr_old = cnt_rd_data;
    endcase
  end

  always_comb begin
    case (op_q)
      SYS_OP_CSRRS: csr_new = csr_old | wdata_q;
      SYS_OP_CSRRC: csr_new = csr_old & ~wdata_q;
      default:      csr_new = wdata_q;
    endcase
  end

  assign csr_we = (state == ST_CSR_RMW) && ((op_q == SYS_OP_CSRRW) || !rs1_zero_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      op_q          <= SYS_OP_CSRRW;
      csr_q         <= '0;
      wdata_q       <= '0;
      rs1_zero_q    <= 1'b0;
      pc_q          <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      priv          <= PRIV_MODE_M;
      mie           <= 1'b0;
      mpie          <= 1'b0;
      mpp           <= PRIV_MODE_U;
      mtvec         <= RESET_MTVEC;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      mscratch      <= '0;
      o_done        <= 1'b0;
      o_redirect    <= 1'b0;
      o_rd_data     <= '0;
      o_redirect_pc <= '0;
    end else begin
      o_done     <= 1'b0;
      o_redirect <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_e) begin
            op_q       <= i_op;
            csr_q      <= i_csr;
            wdata_q    <= i_wdata;
            rs1_zero_q <= i_rs1_is_zero;
            pc_q       <= i_pc;
            cause_q    <= accept_cause;
            tval_q     <= accept_tval;
            state      <= accept_state;
          end
        end
        ST_CSR_RMW: begin
          o_done    <= 1'b1;
          o_rd_data <= csr_old;
          if (csr_we) begin
            case (csr_q)
              CSR_MSTATUS: begin
                mie  <= csr_new[MSTATUS_MIE_BIT];
                mpie <= csr_new[MSTATUS_MPIE_BIT];
                if (csr_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] != 2'b10)
                  mpp <= csr_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
              end
              CSR_MTVEC:    mtvec    <= {csr_new[31:2], 2'b00};
              CSR_MEPC:     mepc     <= {csr_new[31:2], 2'b00};
              CSR_MCAUSE:   mcause   <= csr_new;
              CSR_MTVAL:    mtval    <= csr_new;
              CSR_MSCRATCH: mscratch <= csr_new;
              default: ;
            endcase
          end
          state <= ST_IDLE;
        end
        ST_TRAP_SAVE: begin
          mepc   <= {pc_q[31:2], 2'b00};
          mcause <= cause_q;
          mtval  <= tval_q;
          mpie   <= mie;
          mie    <= 1'b0;
          mpp    <= priv;
          priv   <= PRIV_MODE_M;
          state  <= ST_TRAP_JUMP;
        end
        ST_TRAP_JUMP: begin
          o_done        <= 1'b1;
          o_redirect    <= 1'b1;
          o_redirect_pc <= mtvec;
          o_rd_data     <= '0;
          state         <= ST_IDLE;
        end
        ST_RET: begin
          priv          <= mpp;
          mie           <= mpie;
          mpie          <= 1'b1;
          mpp           <= PRIV_MODE_U;
          o_done        <= 1'b1;
          o_redirect    <= 1'b1;
          o_redirect_pc <= mepc;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_commit.sv
// Directed self-checking bench for sys_commit: CSR RMW, trap entry, MRET,
// counters and reset during an in-flight trap.
module tb_sys_commit;
  import sys_commit_pkg::*;

  logic           clk;
  logic           rst;
  logic           e;
  decode_sys_op_t op;
  logic [11:0]    csr;
  logic [31:0]    wdata;
  logic           rs1_zero;
  logic           bad_csr;
  logic           trap;
  logic [31:0]    pc;
  logic [31:0]    instr;
  logic           retire;
  logic           ready;
  logic           done;
  logic [31:0]    rd_data;
  logic           redirect;
  logic [31:0]    redirect_pc;
  program_state_t ps;

  int n_checks;
  int n_errors;

  logic [31:0] last_rd;
  logic        last_redir;
  logic [31:0] last_rpc;
  int          last_lat;

  sys_commit #(.HART_ID(32'd0), .RESET_MTVEC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_e           (e),
    .i_op          (op),
    .i_csr         (csr),
    .i_wdata       (wdata),
    .i_rs1_is_zero (rs1_zero),
    .i_bad_csr     (bad_csr),
    .i_trap        (trap),
    .i_pc          (pc),
    .i_instr       (instr),
    .i_retire      (retire),
    .o_ready       (ready),
    .o_done        (done),
    .o_rd_data     (rd_data),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_ps          (ps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op from IDLE and waits (bounded) for o_done; latency counts edges from start.
  task automatic sys_op(input decode_sys_op_t o, input logic [11:0] c, input logic [31:0] w,
                        input logic z, input logic bad, input logic [31:0] p,
                        input logic [31:0] ins);
    int lat;
    op       = o;
    csr      = c;
    wdata    = w;
    rs1_zero = z;
    bad_csr  = bad;
    trap     = !(o inside {SYS_OP_CSRRW, SYS_OP_CSRRS, SYS_OP_CSRRC});
    pc       = p;
    instr    = ins;
    e        = 1'b1;
    @(posedge clk); #1;
    e   = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("op_timeout", {31'd0, done}, 32'd1);
    last_rd    = rd_data;
    last_redir = redirect;
    last_rpc   = redirect_pc;
    last_lat   = lat;
  endtask

  task automatic csr_wr(input logic [11:0] c, input logic [31:0] w);
    sys_op(SYS_OP_CSRRW, c, w, (w == 32'd0), 1'b0, 32'h0, 32'h0);
  endtask

  task automatic csr_rd(input logic [11:0] c);
    sys_op(SYS_OP_CSRRS, c, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; e = 1'b0; op = SYS_OP_CSRRW; csr = '0; wdata = '0; rs1_zero = 1'b0;
    bad_csr = 1'b0; trap = 1'b0; pc = '0; instr = '0; retire = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_M});

    // mscratch RMW flavours
    csr_wr(CSR_MSCRATCH, 32'hdead_beef);
    check("rw_rd_old", last_rd, 32'h0);
    check("csr_latency", last_lat, 32'd2);
    check("csr_no_redirect", {31'd0, last_redir}, 32'd0);
    csr_rd(CSR_MSCRATCH);
    check("rs_zero_rd", last_rd, 32'hdead_beef);
    sys_op(SYS_OP_CSRRS, CSR_MSCRATCH, 32'hffff_ffff, 1'b1, 1'b0, 32'h0, 32'h0);
    csr_rd(CSR_MSCRATCH);
    check("rs_zero_skip", last_rd, 32'hdead_beef);
    sys_op(SYS_OP_CSRRC, CSR_MSCRATCH, 32'h0000_ffff, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rc_rd_old", last_rd, 32'hdead_beef);
    sys_op(SYS_OP_CSRRS, CSR_MSCRATCH, 32'h0000_00ff, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rs_rd_old", last_rd, 32'hdead_0000);
    csr_rd(CSR_MSCRATCH);
    check("rs_result", last_rd, 32'hdead_00ff);

    // mtvec alignment, constants, unimplemented CSR
    csr_wr(CSR_MTVEC, 32'h8000_0003);
    csr_rd(CSR_MTVEC);
    check("mtvec_align", last_rd, 32'h8000_0000);
    csr_rd(CSR_MISA);
    check("misa", last_rd, 32'h4000_1101);
    csr_wr(CSR_MHARTID, 32'h55);
    check("mhartid", last_rd, 32'h0);
    csr_wr(12'h7c0, 32'h1234);
    csr_rd(12'h7c0);
    check("unimpl_csr", last_rd, 32'h0);

    // mstatus field masking and MPP=2'b10 rejection
    csr_wr(CSR_MSTATUS, 32'hffff_1888);
    csr_rd(CSR_MSTATUS);
    check("mstatus_mask", last_rd, 32'h0000_1888);
    csr_wr(CSR_MSTATUS, 32'h0000_1000);
    csr_rd(CSR_MSTATUS);
    check("mstatus_mpp10", last_rd, 32'h0000_1800);
    csr_wr(CSR_MSTATUS, 32'h0);

    // MRET into U
    csr_wr(CSR_MEPC, 32'h0000_0203);
    csr_rd(CSR_MEPC);
    check("mepc_align", last_rd, 32'h0000_0200);
    sys_op(SYS_OP_MRET, 12'h302, 32'h0, 1'b1, 1'b0, 32'h40, 32'h3020_0073);
    check("mret_u_lat", last_lat, 32'd2);
    check("mret_u_redir", {31'd0, last_redir}, 32'd1);
    check("mret_u_pc", last_rpc, 32'h0000_0200);
    check("mret_u_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_U});

    // ECALL from U
    sys_op(SYS_OP_ECALL, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0073);
    check("ecall_u_lat", last_lat, 32'd3);
    check("ecall_u_redir", {31'd0, last_redir}, 32'd1);
    check("ecall_u_pc", last_rpc, 32'h8000_0000);
    check("ecall_u_rd", last_rd, 32'h0);
    check("ecall_u_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_M});
    csr_rd(CSR_MCAUSE);
    check("ecall_u_mcause", last_rd, 32'd8);
    csr_rd(CSR_MEPC);
    check("ecall_u_mepc", last_rd, 32'h0000_0100);
    csr_rd(CSR_MTVAL);
    check("ecall_u_mtval", last_rd, 32'h0);
    csr_rd(CSR_MSTATUS);
    check("ecall_u_mstatus", last_rd, 32'h0);

    // Illegal CSR from the checker
    sys_op(SYS_OP_CSRRW, CSR_CYCLE, 32'h1, 1'b0, 1'b1, 32'h0000_0300, 32'hc000_1073);
    check("badcsr_lat", last_lat, 32'd3);
    check("badcsr_pc", last_rpc, 32'h8000_0000);
    csr_rd(CSR_MCAUSE);
    check("badcsr_mcause", last_rd, 32'd2);
    csr_rd(CSR_MTVAL);
    check("badcsr_mtval", last_rd, 32'hc000_1073);
    csr_rd(CSR_MSTATUS);
    check("badcsr_mstatus", last_rd, 32'h0000_1800);

    // EBREAK
    sys_op(SYS_OP_EBREAK, 12'h1, 32'h0, 1'b1, 1'b0, 32'h0000_0404, 32'h0010_0073);
    csr_rd(CSR_MCAUSE);
    check("ebreak_mcause", last_rd, 32'd3);
    csr_rd(CSR_MTVAL);
    check("ebreak_mtval", last_rd, 32'h0000_0404);

    // MRET into S with MPIE set
    csr_wr(CSR_MEPC, 32'h0000_2004);
    csr_wr(CSR_MSTATUS, 32'h0000_0880);
    sys_op(SYS_OP_MRET, 12'h302, 32'h0, 1'b1, 1'b0, 32'h50, 32'h3020_0073);
    check("mret_s_lat", last_lat, 32'd2);
    check("mret_s_pc", last_rpc, 32'h0000_2004);
    check("mret_s_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_S});
    csr_rd(CSR_MSTATUS);
    check("mret_s_mstatus", last_rd, 32'h0000_0088);

    // ECALL from S
    sys_op(SYS_OP_ECALL, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0073);
    csr_rd(CSR_MCAUSE);
    check("ecall_s_mcause", last_rd, 32'd9);
    csr_rd(CSR_MSTATUS);
    check("ecall_s_mstatus", last_rd, 32'h0000_0880);

    // MRET below M is illegal
    sys_op(SYS_OP_MRET, 12'h302, 32'h0, 1'b1, 1'b0, 32'h60, 32'h3020_0073);
    check("mret_s2_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_S});
    sys_op(SYS_OP_MRET, 12'h302, 32'h0, 1'b1, 1'b0, 32'h0000_0600, 32'h3020_0073);
    check("mret_ill_lat", last_lat, 32'd3);
    check("mret_ill_pc", last_rpc, 32'h8000_0000);
    csr_rd(CSR_MCAUSE);
    check("mret_ill_mcause", last_rd, 32'd2);
    csr_rd(CSR_MTVAL);
    check("mret_ill_mtval", last_rd, 32'h3020_0073);

    // SRET illegal, ECALL from M
    sys_op(SYS_OP_SRET, 12'h102, 32'h0, 1'b1, 1'b0, 32'h0000_0700, 32'h1020_0073);
    csr_rd(CSR_MCAUSE);
    check("sret_mcause", last_rd, 32'd2);
    sys_op(SYS_OP_ECALL, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0073);
    csr_rd(CSR_MCAUSE);
    check("ecall_m_mcause", last_rd, 32'd11);

    // Counters: low-word wrap carries into the high word; writes override the tick
    csr_wr(CSR_MCYCLE, 32'hffff_ffff);
    csr_rd(CSR_CYCLE);
    check("cycle_wrap_lo", last_rd, 32'h0);
    csr_rd(CSR_CYCLEH);
    check("cycle_wrap_hi", last_rd, 32'd1);
    csr_rd(CSR_TIMEH);
    check("timeh_alias", last_rd, 32'd1);
    csr_wr(CSR_MCYCLE, 32'd5);
    csr_rd(CSR_MCYCLE);
    check("mcycle_wr", last_rd, 32'd6);
    csr_wr(CSR_MINSTRET, 32'd10);
    retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 retire = 1'b0;
    csr_rd(CSR_INSTRET);
    check("instret_tick", last_rd, 32'd13);
    csr_rd(CSR_INSTRETH);
    check("instreth", last_rd, 32'd0);

    // Reset while in TRAP_SAVE
    csr_wr(CSR_MSCRATCH, 32'h1234_5678);
    op = SYS_OP_ECALL; csr = '0; wdata = '0; rs1_zero = 1'b1; bad_csr = 1'b0;
    trap = 1'b1; pc = 32'h0000_0900; instr = 32'h0000_0073;
    e = 1'b1;
    @(posedge clk); #1;
    e = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_redir", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    check("rstmid_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check("rstmid_done2", {31'd0, done}, 32'd0);
    check("rstmid_redir2", {31'd0, redirect}, 32'd0);
    check("rstmid_priv", {30'd0, ps.priv}, {30'd0, PRIV_MODE_M});
    csr_rd(CSR_MSCRATCH);
    check("rstmid_mscratch", last_rd, 32'h0);
    csr_rd(CSR_MTVEC);
    check("rstmid_mtvec", last_rd, 32'h0);
    csr_rd(CSR_MEPC);
    check("rstmid_mepc", last_rd, 32'h0);
    csr_rd(CSR_MCAUSE);
    check("rstmid_mcause", last_rd, 32'h0);
    csr_rd(CSR_MSTATUS);
    check("rstmid_mstatus", last_rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
